// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: one master's request/response channel into data_mem_arbiter
//   req/write/lock/addr/wdata : master -> arbiter request
//   gnt                       : arbiter -> master, access accepted this cycle
//   rvalid/rdata              : arbiter -> master, registered read response
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic req, write, lock, gnt, rvalid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  modport master (output req, write, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave (input req, write, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-master arbiter (round-robin or fixed, lockable bursts) in front of data_memory
//   clk, reset     : clock, async active-high reset
//   m0, m1         : master channels (m0 = pipeline MEM stage, m1 = DMA/debug)
//   cpu_stall      : m0 requesting but not granted
//   mem_*          : single-port memory bus, combinational read data returned on mem_read_data
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_arbiter_if.slave m0,
  data_mem_arbiter_if.slave m1,
  output logic              cpu_stall,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic rr_ptr, owner_valid, owner, rvalid0, rvalid1;
  logic [CW-1:0] lock_cnt;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic any_req, owner_req, other_req, cap, own_win, sel, wr, lk, rd0, rd1;
  always_comb begin
    any_req = m0.req | m1.req;
    owner_req = owner ? m1.req : m0.req;
    other_req = owner ? m0.req : m1.req;
    cap = (lock_cnt == CW'(MAX_LOCK)) && other_req;
    own_win = owner_valid && owner_req && !cap;
    // a capped owner that still requests must yield, regardless of priority mode
    sel = own_win ? owner :
          (owner_valid && owner_req) ? ~owner :
          (m0.req && m1.req) ? ((FIXED_PRIO != 0) ? 1'b0 : rr_ptr) : m1.req;
    wr = sel ? m1.write : m0.write;
    lk = sel ? m1.lock : m0.lock;
    rd0 = any_req && !sel && !wr;
    rd1 = any_req && sel && !wr;
  end
  assign m0.gnt = any_req & ~sel;
  assign m1.gnt = any_req & sel;
  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.rdata = rdata0;
  assign m1.rdata = rdata1;
  assign cpu_stall = m0.req & ~m0.gnt;
  assign mem_write = any_req & wr & ~reset;
  assign mem_address = any_req ? (sel ? m1.addr : m0.addr) : '0;
  assign mem_write_data = any_req ? (sel ? m1.wdata : m0.wdata) : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= 1'b0;
      owner_valid <= 1'b0;
      owner <= 1'b0;
      lock_cnt <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      rvalid0 <= rd0;
      rvalid1 <= rd1;
      if (rd0) rdata0 <= mem_read_data;
      if (rd1) rdata1 <= mem_read_data;
      if (any_req) begin
        rr_ptr <= ~sel;
        owner_valid <= lk;
        if (lk) owner <= sel;
        // counter saturates so an uncontested burst caps at once when the other master arrives
        lock_cnt <= !lk ? '0 :
                    (owner_valid && owner == sel) ?
                      ((lock_cnt == CW'(MAX_LOCK)) ? lock_cnt : lock_cnt + CW'(1)) : CW'(1);
      end else begin
        owner_valid <= 1'b0;
        lock_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed checks of round-robin, fixed priority, lock cap, async reset, lock release
module tb_data_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic r0, w0, l0, r1, w1, l1;
  logic [31:0] ad0, wd0, ad1, wd1;
  logic st_a, mw_a, st_b, mw_b;
  logic [31:0] ma_a, md_a, mr_a, ma_b, md_b, mr_b;
  logic [31:0] ram_a [0:63];
  logic [31:0] ram_b [0:63];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_arbiter_if #(32, 32) a0 ();
  data_mem_arbiter_if #(32, 32) a1 ();
  data_mem_arbiter_if #(32, 32) b0 ();
  data_mem_arbiter_if #(32, 32) b1 ();

  assign a0.req = r0;  assign a0.write = w0;  assign a0.lock = l0;  assign a0.addr = ad0;  assign a0.wdata = wd0;
  assign a1.req = r1;  assign a1.write = w1;  assign a1.lock = l1;  assign a1.addr = ad1;  assign a1.wdata = wd1;
  assign b0.req = r0;  assign b0.write = w0;  assign b0.lock = l0;  assign b0.addr = ad0;  assign b0.wdata = wd0;
  assign b1.req = r1;  assign b1.write = w1;  assign b1.lock = l1;  assign b1.addr = ad1;  assign b1.wdata = wd1;

  data_mem_arbiter #(.FIXED_PRIO(0), .MAX_LOCK(4)) ua (
    .clk(clk), .reset(reset), .m0(a0), .m1(a1), .cpu_stall(st_a), .mem_write(mw_a),
    .mem_address(ma_a), .mem_write_data(md_a), .mem_read_data(mr_a));

  data_mem_arbiter #(.FIXED_PRIO(1), .MAX_LOCK(4)) ub (
    .clk(clk), .reset(reset), .m0(b0), .m1(b1), .cpu_stall(st_b), .mem_write(mw_b),
    .mem_address(ma_b), .mem_write_data(md_b), .mem_read_data(mr_b));

  initial for (int i = 0; i < 64; i++) begin
    ram_a[i] = i;
    ram_b[i] = i;
  end
  always @(posedge clk) if (mw_a) ram_a[ma_a[7:2]] <= md_a;
  always @(posedge clk) if (mw_b) ram_b[ma_b[7:2]] <= md_b;
  assign mr_a = ram_a[ma_a[7:2]];
  assign mr_b = ram_b[ma_b[7:2]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic q0, x0, k0, input logic [31:0] a_0, d_0,
                     input logic q1, x1, k1, input logic [31:0] a_1, d_1);
    r0 = q0; w0 = x0; l0 = k0; ad0 = a_0; wd0 = d_0;
    r1 = q1; w1 = x1; l1 = k1; ad1 = a_1; wd1 = d_1;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_gnt", {a0.gnt, a1.gnt, b0.gnt, b1.gnt}, 0);
    chk("rst_rvalid", {a0.rvalid, a1.rvalid}, 0);
    chk("rst_rdata", {a0.rdata, a1.rdata}, 0);
    chk("rst_mem", {mw_a, st_a, ma_a, md_a}, 0);

    cyc();
    drv(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("solo_gnt0", a0.gnt, 1);
    chk("solo_gnt1", a1.gnt, 0);
    chk("solo_stall", st_a, 0);
    chk("solo_addr", ma_a, 32'h10);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("solo_rvalid", a0.rvalid, 1);
    chk("solo_rdata", a0.rdata, 4);
    chk("solo_gnt_drop", a0.gnt, 0);
    cyc();
    @(negedge clk);
    chk("solo_rvalid_pulse", a0.rvalid, 0);

    cyc();
    do_reset();
    drv(1, 0, 0, 32'h0, 0, 1, 0, 0, 32'h4, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_gnt0", a0.gnt, (i % 2) == 0);
      chk("rr_gnt1", a1.gnt, (i % 2) == 1);
      chk("rr_stall", st_a, (i % 2) == 1);
      chk("fp_gnt0", b0.gnt, 1);
      chk("fp_gnt1", b1.gnt, 0);
      chk("fp_stall", st_b, 0);
      if (i > 0) begin
        chk("rr_rvalid0", a0.rvalid, (i % 2) == 1);
        chk("rr_rvalid1", a1.rvalid, (i % 2) == 0);
        chk("fp_rvalid0", b0.rvalid, 1);
        if ((i % 2) == 0) chk("rr_rdata1", a1.rdata, 1);
        else chk("rr_rdata0", a0.rdata, 0);
      end
      cyc();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rr_last_rvalid1", a1.rvalid, 1);
    chk("rr_last_rdata1", a1.rdata, 1);

    cyc();
    do_reset();
    drv(0, 0, 0, 0, 0, 1, 1, 1, 32'h20, 32'hDEADBEEF);
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) drv(1, 0, 0, 32'h20, 0, 1, 1, 1, 32'h20, 32'hDEADBEEF);
      if (c == 6) drv(0, 0, 0, 0, 0, 1, 1, 1, 32'h20, 32'hDEADBEEF);
      @(negedge clk);
      chk("lock_gnt1", a1.gnt, c != 5);
      chk("lock_gnt0", a0.gnt, c == 5);
      chk("lock_stall", st_a, c >= 2 && c <= 4);
      chk("lock_mem_write", mw_a, c != 5);
      if (c == 5) chk("lock_cnt_cap", ua.lock_cnt, 4);
      if (c == 6) begin
        chk("lock_rvalid0", a0.rvalid, 1);
        chk("lock_rdata0", a0.rdata, 32'hDEADBEEF);
      end
      cyc();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lock_ram", ram_a[8], 32'hDEADBEEF);

    do_reset();
    drv(1, 0, 1, 32'h0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ar_gnt0", a0.gnt, 1);
    cyc();
    drv(1, 1, 1, 32'h8, 32'h55, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ar_mem_write", mw_a, 1);
    chk("ar_owner_set", ua.owner_valid, 1);
    chk("ar_rvalid_pre", a0.rvalid, 1);
    #1 reset = 1'b1;
    #1;
    chk("ar_mem_write_drop", mw_a, 0);
    chk("ar_rvalid_clr", {a0.rvalid, a1.rvalid}, 0);
    chk("ar_owner_clr", ua.owner_valid, 0);
    cyc();
    chk("ar_ram_kept", ram_a[2], 2);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("ar_lock_cnt", ua.lock_cnt, 0);
    chk("ar_rvalid_post", {a0.rvalid, a1.rvalid}, 0);

    cyc();
    drv(1, 0, 1, 32'h0, 0, 1, 0, 0, 32'h4, 0);
    @(negedge clk);
    chk("rel_gnt0", a0.gnt, 1);
    chk("rel_gnt1_wait", a1.gnt, 0);
    cyc();
    chk("rel_owner_set", ua.owner_valid, 1);
    drv(0, 0, 0, 0, 0, 1, 0, 0, 32'h4, 0);
    @(negedge clk);
    chk("rel_gnt1", a1.gnt, 1);
    chk("rel_gnt0_drop", a0.gnt, 0);
    chk("rel_stall", st_a, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rel_owner_clr", ua.owner_valid, 0);
    chk("rel_rvalid1", a1.rvalid, 1);
    chk("rel_rdata1", a1.rdata, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
